// File: rtl/fetch_stage_if.sv
// fetch_stage_if: ROM, IF/ID handshake and redirect signals of the fetch stage
interface fetch_stage_if;
  logic        ID_allow_in;
  logic [32:0] jbr_bus;
  logic [32:0] exc_bus;
  logic        inst_rom_en;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        IF_valid;
  logic        IF_over;
  logic [63:0] IF_ID_bus;
  logic [31:0] IF_pc;
  modport master (
    input  ID_allow_in, jbr_bus, exc_bus, inst,
    output inst_rom_en, inst_addr, IF_valid, IF_over, IF_ID_bus, IF_pc
  );
  modport slave (
    output ID_allow_in, jbr_bus, exc_bus, inst,
    input  inst_rom_en, inst_addr, IF_valid, IF_over, IF_ID_bus, IF_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage; FETCH_INST_HOLD_EN holds inst after the first DONE cycle and idles the ROM
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ROM_LATENCY = 1
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);
  typedef enum logic [1:0] {REQ, WAIT, DONE} state_t;
  localparam logic [1:0] LAST = 2'(ROM_LATENCY - 1);
  state_t      state, state_n;
  logic [31:0] pc, pc_n, jbr_pend_pc, next_pc, inst_cur;
  logic [1:0]  lat_cnt, lat_cnt_n;
  logic        jbr_pend, exc, jbr_taken, over, xfer, rom_en_done;
  assign exc       = bus.exc_bus[32];
  assign jbr_taken = bus.jbr_bus[32];
  assign over      = state == DONE && !exc && !reset;
  assign xfer      = over && bus.ID_allow_in;
  assign next_pc   = jbr_taken ? bus.jbr_bus[31:0] : jbr_pend ? jbr_pend_pc : pc + 32'd4;
`ifdef FETCH_INST_HOLD_EN
  logic        held;
  logic [31:0] inst_hold;
  always_ff @(posedge clk) begin
    held <= !reset && state == DONE && !exc && !xfer;
    if (state == DONE && !held) inst_hold <= bus.inst;
  end
  assign inst_cur    = held ? inst_hold : bus.inst;
  assign rom_en_done = !held;
`else
  assign inst_cur    = bus.inst;
  assign rom_en_done = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      lat_cnt     <= 2'd0;
      jbr_pend    <= 1'b0;
      jbr_pend_pc <= 32'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      lat_cnt     <= lat_cnt_n;
      jbr_pend    <= (exc || xfer) ? 1'b0 : jbr_taken ? 1'b1 : jbr_pend;
      jbr_pend_pc <= (jbr_taken && !exc && !xfer) ? bus.jbr_bus[31:0] : jbr_pend_pc;
    end
  end
  // exception redirect overrides every state and drops any in-flight ROM result
  always_comb begin
    state_n         = exc ? REQ
                    : state == REQ  ? (ROM_LATENCY > 1 ? WAIT : DONE)
                    : state == WAIT ? (lat_cnt == LAST ? DONE : WAIT)
                    : xfer ? REQ : state;
    pc_n            = exc ? bus.exc_bus[31:0] : xfer ? next_pc : pc;
    lat_cnt_n       = exc ? 2'd0 : state == REQ ? 2'd1 : state == WAIT ? lat_cnt + 2'd1 : lat_cnt;
    bus.inst_rom_en = !reset && (state != DONE || rom_en_done);
    bus.inst_addr   = pc;
    bus.IF_valid    = !reset;
    bus.IF_over     = over;
    bus.IF_ID_bus   = reset ? 64'd0 : {pc, inst_cur};
    bus.IF_pc       = pc;
  end
endmodule
